data_memory_stage: RTL and testbench
====================================

Name: data_memory_stage

Overview:
- Byte-addressed, little-endian data memory for the 64-bit RISC-V pipeline's MEM stage.
- Driven by EX/MEM pipeline register outputs: ALU result as address, rs2 data, MemRead/MemWrite, funct3.
- Read_Data is combinational within the cycle so the MEM/WB register latches it on the next clk edge.
- Stores commit on clk edge; access faults are flagged and held sticky.

Parameters:
- DEPTH_BYTES, 512, number of bytes of storage; must be a power of two and a multiple of 8.
- ADDR_W, 9, index width, equals log2(DEPTH_BYTES).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high.
- Address  input  64  byte address (ALU result from EX/MEM).
- Write_Data  input  64  store data; low bytes used per size.
- MemRead  input  1  load request this cycle.
- MemWrite  input  1  store request this cycle.
- funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU, 111 illegal.
- Read_Data  output  64  extended load result, combinational.
- fault  output  1  combinational: current access is illegal.
- fault_sticky  output  1  registered: any fault seen since reset.
- store_count  output  16  registered count of committed stores, saturating.

Behaviour:
- Reset: clock and reset per "Already decided": clock clk; reset reset, asynchronous, active-high.
  - Reset clears all DEPTH_BYTES bytes to 0, fault_sticky=0, store_count=0.
  - Read_Data=0 and fault=0 while reset is high.
  - Reset dominates a same-cycle store; no byte is written.
- Size and sign decoding:
  - size = 1/2/4/8 bytes from funct3[1:0].
  - Loads with funct3[2]=0 sign-extend; funct3[2]=1 zero-extend.
  - funct3=111 is illegal for loads.
  - Any funct3 with bit2=1 is illegal for stores.
- Fault checks:
  - misaligned = Address mod size != 0.
  - out_of_range = Address >= DEPTH_BYTES, or Address+size-1 >= DEPTH_BYTES. No wrap-around; upper Address bits are not ignored.
  - fault = (MemRead|MemWrite) & (misaligned | out_of_range | illegal funct3 for the requested op).
- Load (MemRead=1, no fault):
  - Read_Data = bytes [Address .. Address+size-1] assembled little-endian (lowest address in bits 7:0), then extended to 64 bits.
  - Zero latency; reflects current array contents.
- Load with fault, or MemRead=0: Read_Data = 0.
- Store (MemWrite=1, no fault):
  - At rising clk, bytes Address..Address+size-1 <= Write_Data[8*size-1:0], little-endian.
  - Other bytes untouched.
  - store_count increments by 1 and saturates at 16'hFFFF.
- Store with fault: no bytes written; store_count unchanged.
- fault_sticky: set at rising clk when fault=1; cleared only by reset.
- MemRead and MemWrite both 1 with no fault:
  - Read_Data shows pre-write contents in that cycle (read-before-write).
  - Store commits at the edge.
  - Fault evaluation uses load legality OR store legality; either failing suppresses the store and zeros Read_Data.
- Read-after-write to the same address in the following cycle returns the new data; there is no internal bypass.

Test Plan:
- Reset, then LD at Address 0x0 -> Read_Data=0, fault=0, fault_sticky=0, store_count=0.
- SD 0x8877665544332211 at 0x10, then next cycle LB at 0x10 -> 0x11; LH at 0x12 -> 0x4433; LW at 0x14 -> 0xFFFFFFFF88776655; LWU at 0x14 -> 0x0000000088776655; store_count=1.
- SB 0xAB at 0x11 over the prior data, then LD at 0x10 -> 0x887766554433AB11; LBU at 0x11 -> 0xAB; LB at 0x11 -> 0xFFFFFFFFFFFFFFAB.
- LW at 0x13 (misaligned) -> fault=1, Read_Data=0, fault_sticky=1 after edge. SD at 0x200 (out of range, DEPTH_BYTES=512) -> fault=1, no write, store_count unchanged. SB with funct3=100 -> fault=1.
- MemRead=MemWrite=1, SD 0xDEADBEEF at 0x20 that held 0 -> Read_Data=0 that cycle; LD at 0x20 next cycle -> 0x00000000DEADBEEF.
- Assert reset asynchronously mid-cycle during an SD to 0x30 -> fault_sticky=0, store_count=0 immediately. Later LD at 0x30 -> 0; LD at 0x10 -> 0 (array cleared).

Source files
------------

// File: rtl/data_memory_stage_if.sv
// data_memory_stage_if
//   Bundles the EX/MEM-side request signals and the MEM-stage results of the
//   data memory so that the pipeline and the memory connect through one port.
//   master: pipeline side. It drives Address/Write_Data/MemRead/MemWrite/funct3
//           and receives Read_Data/fault/fault_sticky/store_count.
//   slave : memory side. It has the opposite directions.
interface data_memory_stage_if;
    logic [63:0] Address;
    logic [63:0] Write_Data;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [63:0] Read_Data;
    logic        fault;
    logic        fault_sticky;
    logic [15:0] store_count;

    modport master (
        output Address, Write_Data, MemRead, MemWrite, funct3,
        input  Read_Data, fault, fault_sticky, store_count
    );

    modport slave (
        input  Address, Write_Data, MemRead, MemWrite, funct3,
        output Read_Data, fault, fault_sticky, store_count
    );
endinterface

// File: rtl/data_memory_stage.sv
// data_memory_stage
//   Byte-addressed, little-endian data memory for the MEM stage of the
//   64-bit RISC-V pipeline. Loads are combinational, so the MEM/WB register
//   captures Read_Data on the next edge. Stores commit on the rising clk
//   edge. Illegal, misaligned or out-of-range accesses raise fault and set a
//   sticky flag.
//   Ports:
//     clk   - pipeline clock, rising edge
//     reset - asynchronous, active-high; clears the array, the sticky flag
//             and the store counter
//     bus   - data_memory_stage_if.slave:
//             Address, Write_Data, MemRead, MemWrite, funct3 (inputs)
//             Read_Data, fault (combinational outputs)
//             fault_sticky, store_count (registered outputs)
module data_memory_stage #(
    parameter int DEPTH_BYTES = 512,
    parameter int ADDR_W      = 9
) (
    input  logic                clk,
    input  logic                reset,
    data_memory_stage_if.slave  bus
);

    logic [7:0]        mem [DEPTH_BYTES];

    logic [7:0]        byte_mask;   // bytes that take part in the access
    logic [2:0]        align_mask;  // access size minus one
    logic [63:0]       bit_mask;
    logic [64:0]       last_addr;   // 65 bits, so Address+size-1 cannot wrap
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] lane_addr [8];
    logic [63:0]       raw;
    logic              sign_bit;
    logic              misaligned;
    logic              out_of_range;
    logic              load_illegal;
    logic              store_illegal;
    logic              fault_c;
    logic              store_en;
    logic              fault_sticky_q;
    logic [15:0]       store_count_q;

    assign base = bus.Address[ADDR_W-1:0];

    always_comb begin
        byte_mask  = 8'h01;
        align_mask = 3'd0;
        case (bus.funct3[1:0])
            2'b00:   begin byte_mask = 8'h01; align_mask = 3'd0; end
            2'b01:   begin byte_mask = 8'h03; align_mask = 3'd1; end
            2'b10:   begin byte_mask = 8'h0F; align_mask = 3'd3; end
            default: begin byte_mask = 8'hFF; align_mask = 3'd7; end
        endcase
    end

    always_comb begin
        last_addr     = {1'b0, bus.Address} + 65'(align_mask);
        misaligned    = |(bus.Address[2:0] & align_mask);
        out_of_range  = last_addr >= 65'(DEPTH_BYTES);
        load_illegal  = bus.MemRead  && (bus.funct3 == 3'b111);
        store_illegal = bus.MemWrite && bus.funct3[2];
        fault_c       = !reset && (bus.MemRead || bus.MemWrite) &&
                        (misaligned || out_of_range || load_illegal || store_illegal);
        store_en      = bus.MemWrite && !fault_c;
    end

    // Lane addresses wrap within the index width. That only matters for
    // accesses that are already flagged out of range, which are never
    // committed and read back as zero.
    always_comb begin
        bit_mask = '0;
        raw      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            lane_addr[i]      = base + ADDR_W'(i);
            bit_mask[8*i +: 8] = {8{byte_mask[i]}};
            raw[8*i +: 8]      = mem[lane_addr[i]] & {8{byte_mask[i]}};
        end
    end

    always_comb begin
        sign_bit = 1'b0;
        case (bus.funct3[1:0])
            2'b00:   sign_bit = raw[7];
            2'b01:   sign_bit = raw[15];
            2'b10:   sign_bit = raw[31];
            default: sign_bit = raw[63];
        endcase
    end

    always_comb begin
        bus.Read_Data = '0;
        if (!reset && bus.MemRead && !fault_c) begin
            if (!bus.funct3[2] && sign_bit)
                bus.Read_Data = raw | ~bit_mask;
            else
                bus.Read_Data = raw;
        end
    end

    assign bus.fault        = fault_c;
    assign bus.fault_sticky = fault_sticky_q;
    assign bus.store_count  = store_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned j = 0; j < DEPTH_BYTES; j++)
                mem[j] <= '0;
            fault_sticky_q <= 1'b0;
            store_count_q  <= '0;
        end else begin
            if (fault_c)
                fault_sticky_q <= 1'b1;
            if (store_en) begin
                for (int unsigned i = 0; i < 8; i++)
                    if (byte_mask[i])
                        mem[lane_addr[i]] <= bus.Write_Data[8*i +: 8];
                if (store_count_q != '1)
                    store_count_q <= store_count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_stage.sv
// tb_data_memory_stage
//   Scoreboard bench for data_memory_stage. The driver applies one access
//   per cycle, shortly after the rising edge. It computes the expected
//   outputs from a byte-array reference model and queues them. A monitor
//   samples the DUT on the falling edge and compares it with the queued
//   expectations.
module tb_data_memory_stage;

    localparam int DEPTH = 512;

    logic clk;
    logic reset;

    data_memory_stage_if bus();

    data_memory_stage #(.DEPTH_BYTES(DEPTH), .ADDR_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rd;
        logic        flt;
        logic        stk;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  mm [DEPTH];
    bit          m_sticky;
    int unsigned m_count;
    int unsigned checks;
    int unsigned fails;

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) mm[k] = 8'h00;
        m_sticky = 1'b0;
        m_count  = 0;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] wd,
                         input logic r, input logic w, input logic [2:0] f3);
        bus.Address    = a;
        bus.Write_Data = wd;
        bus.MemRead    = r;
        bus.MemWrite   = w;
        bus.funct3     = f3;
    endtask

    task automatic push_zero(input string nm);
        exp_t e;
        e = '{rd: 64'd0, flt: 1'b0, stk: 1'b0, cnt: 16'd0, name: nm};
        q.push_back(e);
    endtask

    // One access for one cycle. The expectation reflects memory contents
    // before the coming edge; the model is updated afterwards.
    task automatic step(input string nm, input logic [63:0] a, input logic [63:0] wd,
                        input logic r, input logic w, input logic [2:0] f3);
        exp_t            e;
        int unsigned     sz;
        bit              bad;
        logic [63:0]     v;
        @(posedge clk);
        #1;
        drive(a, wd, r, w, f3);
        sz  = 1 << f3[1:0];
        bad = 1'b0;
        if (r || w) begin
            if ((a % sz) != 0)                 bad = 1'b1;
            if (a >= DEPTH || a + sz > DEPTH)  bad = 1'b1;
            if (r && f3 == 3'b111)             bad = 1'b1;
            if (w && f3[2])                    bad = 1'b1;
        end
        v = 64'd0;
        if (r && !bad) begin
            for (int k = int'(sz) - 1; k >= 0; k--)
                v = (v << 8) | 64'(mm[int'(a[8:0]) + k]);
            if (!f3[2] && v[8*sz-1] && sz < 8)
                v = v | (~64'd0 << (8*sz));
        end
        e = '{rd: v, flt: bad, stk: m_sticky, cnt: m_count[15:0], name: nm};
        q.push_back(e);
        if (bad) m_sticky = 1'b1;
        if (w && !bad) begin
            for (int k = 0; k < int'(sz); k++)
                mm[int'(a[8:0]) + k] = wd[8*k +: 8];
            if (m_count < 65535) m_count++;
        end
    endtask

    task automatic check(input string nm, input string field,
                         input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s.%s: got %h expected %h", nm, field, act, exp);
        end
    endtask

    // Monitor: compares every queued expectation on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, "Read_Data",    bus.Read_Data,           e.rd);
                check(e.name, "fault",        64'(bus.fault),          64'(e.flt));
                check(e.name, "fault_sticky", 64'(bus.fault_sticky),   64'(e.stk));
                check(e.name, "store_count",  64'(bus.store_count),    64'(e.cnt));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] a;
        logic [2:0]  f3;
        int unsigned sel;
        checks = 0;
        fails  = 0;
        reset  = 1'b1;
        drive(64'd0, 64'd0, 1'b0, 1'b0, 3'b000);
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        step("ld0",     64'h0,  64'h0, 1, 0, 3'b011);
        step("sd10",    64'h10, 64'h8877665544332211, 0, 1, 3'b011);
        step("lb10",    64'h10, 64'h0, 1, 0, 3'b000);
        step("lh12",    64'h12, 64'h0, 1, 0, 3'b001);
        step("lw14",    64'h14, 64'h0, 1, 0, 3'b010);
        step("lwu14",   64'h14, 64'h0, 1, 0, 3'b110);
        step("sb11",    64'h11, 64'hAB, 0, 1, 3'b000);
        step("ld10",    64'h10, 64'h0, 1, 0, 3'b011);
        step("lbu11",   64'h11, 64'h0, 1, 0, 3'b100);
        step("lb11",    64'h11, 64'h0, 1, 0, 3'b000);
        step("lw13mis", 64'h13, 64'h0, 1, 0, 3'b010);
        step("sd200",   64'h200, 64'h1234, 0, 1, 3'b011);
        step("sbu40",   64'h40, 64'h55, 0, 1, 3'b100);
        step("ld200",   64'h200, 64'h0, 1, 0, 3'b011);
        step("ld111",   64'h0,  64'h0, 1, 0, 3'b111);
        step("sd1f8",   64'h1F8, 64'hCAFEF00D12345678, 0, 1, 3'b011);
        step("ld1f8",   64'h1F8, 64'h0, 1, 0, 3'b011);
        step("lbu1ff",  64'h1FF, 64'h0, 1, 0, 3'b100);
        step("lh1ffoor",64'h1FF, 64'h0, 1, 0, 3'b001);
        step("hiaddr",  64'h8000_0000_0000_0010, 64'h0, 1, 0, 3'b011);
        step("rw20",    64'h20, 64'hDEADBEEF, 1, 1, 3'b011);
        step("ld20",    64'h20, 64'h0, 1, 0, 3'b011);

        // Reset rises mid-cycle while a store is presented.
        @(posedge clk);
        #1;
        drive(64'h30, 64'h0123456789ABCDEF, 1'b0, 1'b1, 3'b011);
        #2;
        reset = 1'b1;
        model_clear();
        push_zero("rst_async");
        @(posedge clk);
        #1;
        drive(64'h13, 64'h0, 1'b1, 1'b0, 3'b010);
        push_zero("rst_hold");
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(64'h0, 64'h0, 1'b0, 1'b0, 3'b000);

        step("ld30",    64'h30, 64'h0, 1, 0, 3'b011);
        step("ld10clr", 64'h10, 64'h0, 1, 0, 3'b011);

        for (int n = 0; n < 400; n++) begin
            f3  = 3'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            if (sel == 0)
                a = {$urandom, $urandom};
            else if (sel == 1)
                a = 64'($urandom_range(500, 520));
            else begin
                a = 64'($urandom_range(0, 127));
                if (sel < 8) a = a & ~64'((1 << f3[1:0]) - 1);
            end
            step("rand", a, {$urandom, $urandom}, 1'($urandom), 1'($urandom), f3);
        end

        @(posedge clk);
        #1;
        drive(64'h0, 64'h0, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
